bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Shared-bus controller for the multi-terminal bus the agent/driver env drives.
//  Each terminal owns a FWFT FIFO (depth deep_fifo). The arbiter round-robins
//  among pending FIFOs, pops one packet and routes it to the destination
//  terminal(s) by the ID in the packet's top byte. One packet on the bus at a time.
// PARAMETERS
//  drvrs      4      number of terminals (2..16)
//  pckg_sz    40     packet width in bits; [pckg_sz-1 -: 8] = dest ID, rest = payload
//  broadcast  8'hFF  dest ID meaning "all terminals except source"
// PORTS
//  clk      in   1               single clock, rising edge
//  reset    in   1               asynchronous, active-high
//  pndng    in   drvrs           FIFO i non-empty; D_pop slice i valid while high
//  D_pop    in   drvrs*pckg_sz   head data; slice i = [i*pckg_sz +: pckg_sz]
//  pop      out  drvrs           one-hot, 1-cycle pulse: consume head of FIFO i
//  D_push   out  pckg_sz         packet on bus, valid while any push bit high
//  push     out  drvrs           write strobe per destination FIFO, 1 cycle
//  drop     out  1               1-cycle pulse: packet popped but not delivered
//  busy     out  1               high in any state except IDLE
// BEHAVIOUR
//  Reset (async, while high): state=IDLE; pop=0, push=0, drop=0, busy=0,
//   D_push=0, grant=0, rr_ptr=drvrs-1 (first grant after reset goes to terminal 0).
//  FSM, one transition per clk:
//   IDLE: if |pndng: grant <= first i with pndng[i] searching rr_ptr+1,
//         rr_ptr+2, ... wrapping mod drvrs; -> POP. Else stay.
//   POP : if pndng[grant]: pop[grant]=1 this cycle, pkt <= D_pop[grant];
//         rr_ptr <= grant; -> ROUTE. If pndng[grant] has fallen: no pop,
//         rr_ptr unchanged, -> IDLE.
//   ROUTE: dest=pkt[pckg_sz-1 -: 8]. D_push=pkt; push computed:
//         dest==broadcast -> all bits except grant;
//         dest<drvrs and dest!=grant -> bit dest;
//         otherwise (out of range or self) -> push=0, drop=1. -> IDLE.
//  pop, push and drop are registered (Moore) outputs of the state they belong to.
//  Latency: pndng rises in IDLE at edge t -> pop high t+1..t+2, push high t+2..t+3.
//   3 cycles/packet; back-to-back: next pop 3 cycles after previous pop.
//  Fairness: a terminal that has just been served is searched last; with all
//   pndng high, the grant sequence is 0,1,2,...,drvrs-1,0.
//  Simultaneous: a new pndng rise during POP/ROUTE is sampled in the next IDLE.
//  D_push holds the last packet after ROUTE (no glitching); push is 0 outside ROUTE.
//  Reset mid-packet: a packet already popped but not yet routed is lost; no
//   partial push.
//  No backpressure: destination FIFOs must accept push (full = overwrite/drop
//   is the FIFO's responsibility).
// STRUCTURE
//  Package bus_arb_pkg: typedef enum logic [1:0] {IDLE, POP, ROUTE} arb_state_e;
//   localparam BCAST default; function dest_of(pkt).
//  Sub-module rr_pick #(N): combinational; inputs req[N], last[$clog2(N)];
//   outputs gnt_idx, any. Rotate, priority-encode, rotate back.
//  Top holds FSM, rr_ptr, grant, pkt register and the destination decoder.
// TESTING
//  1 pndng=0001, D_pop[0] dest=2 payload=32'hA5A5A5A5 -> pop=0001 at t+1,
//    push=0100 and D_push=40'h02A5A5A5A5 at t+2.
//  2 pndng=1111 held, FIFOs refilled -> grant order 0,1,2,3,0; pop pulses exactly
//    3 cycles apart.
//  3 term 1 sends dest=8'hFF -> push=1101, drop=0.
//  4 term 3 sends dest=3 (self) and then dest=9 -> push=0000, drop=1 each; pop
//    still issued.
//  5 pndng[2] falls during POP -> no pop, no push, FSM back to IDLE, next grant 2.
//  6 reset asserted during ROUTE -> all outputs 0 asynchronously; after release
//    pndng=1000 -> grant 3, pop=1000.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the FSM state encoding, broadcast ID and destination extraction.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        ROUTE
    } arb_state_e;

    localparam logic [7:0] BCAST   = 8'hFF;
    localparam int         MAX_PKT = 256;

    // Destination ID is the top byte of a w-bit packet.
    function automatic logic [7:0] dest_of(
        input logic [MAX_PKT-1:0] pkt,
        input int unsigned        w
    );
        logic [MAX_PKT-1:0] s;
        s = pkt >> (w - 8);
        return s[7:0];
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Round-robin picker: rotate requests past the last winner,
// priority-encode the lowest set bit, rotate the index back.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             pos;

    always_comb begin
        off = (int'(last_i) + 1) % N;
        dbl = {req_i, req_i} >> off;
        rot = dbl[N-1:0];
        pos = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) pos = k;
        end
        gnt_idx_o = IW'((pos + off) % N);
        any_o     = |req_i;
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared-bus arbiter: round-robins over pending terminal FIFOs,
// pops one packet and routes it to its destination terminal(s).
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 40,
    parameter logic [7:0]  broadcast = BCAST
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [pckg_sz-1:0]         D_push,
    output logic [drvrs-1:0]           push,
    output logic                       drop,
    output logic                       busy
);

    localparam int IW = $clog2(drvrs);
    localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [drvrs-1:0]   pop_q, pop_d;
    logic [drvrs-1:0]   push_q, push_d;
    logic               drop_q, drop_d;

    logic [IW-1:0]      pick;
    logic               any;
    logic [pckg_sz-1:0] head;
    logic [7:0]         dest;
    logic [drvrs-1:0]   gnt_oh;
    logic [drvrs-1:0]   route_push;
    logic               route_drop;

    rr_pick #(.N(drvrs)) u_pick (
        .req_i     (pndng),
        .last_i    (rr_q),
        .gnt_idx_o (pick),
        .any_o     (any)
    );

    // Destination is decoded straight off the FIFO head so push/drop
    // can be registered into ROUTE alongside the packet itself.
    always_comb begin
        head       = D_pop[int'(grant_q)*pckg_sz +: pckg_sz];
        dest       = dest_of(MAX_PKT'(head), pckg_sz);
        gnt_oh     = ONE << grant_q;
        route_push = '0;
        route_drop = 1'b0;
        if (dest == broadcast) begin
            route_push = ~gnt_oh;
        end else if (int'(dest) < drvrs && dest != 8'(grant_q)) begin
            route_push = ONE << dest[IW-1:0];
        end else begin
            route_drop = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        pkt_d   = pkt_q;
        pop_d   = '0;
        push_d  = '0;
        drop_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d = pick;
                    pop_d   = ONE << pick;
                    state_d = POP;
                end
            end
            POP: begin
                if (pndng[grant_q]) begin
                    rr_d    = grant_q;
                    pkt_d   = head;
                    push_d  = route_push;
                    drop_d  = route_drop;
                    state_d = ROUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUTE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= IW'(drvrs - 1);
            pkt_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            pkt_q   <= pkt_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            drop_q  <= drop_d;
        end
    end

    // A head that vanishes mid-POP must not be consumed.
    assign pop    = pop_q & pndng;
    assign push   = push_q;
    assign drop   = drop_q;
    assign D_push = pkt_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter (4 terminals, 40-bit packets).
// Expected values are written out by hand for each step.
module tb_bus_rr_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   pndng = '0;
    logic [159:0] d_pop = '0;
    logic [3:0]   pop;
    logic [39:0]  d_push;
    logic [3:0]   push;
    logic         drop;
    logic         busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    bus_rr_arbiter #(
        .drvrs     (4),
        .pckg_sz   (40),
        .broadcast (8'hFF)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .D_pop  (d_pop),
        .pop    (pop),
        .D_push (d_push),
        .push   (push),
        .drop   (drop),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        repeat (2) @(negedge clk);
        chk({tag, "_pop"},   64'(pop),    64'h0);
        chk({tag, "_push"},  64'(push),   64'h0);
        chk({tag, "_drop"},  64'(drop),   64'h0);
        chk({tag, "_busy"},  64'(busy),   64'h0);
        chk({tag, "_dpush"}, 64'(d_push), 64'h0);
        reset = 1'b0;
    endtask

    // Assumes the arbiter is idle and at a negedge on entry.
    task automatic do_packet(input string tag, input int src,
                             input logic [39:0] data,
                             input logic [3:0] exp_push,
                             input logic exp_drop);
        logic [3:0] m;
        m = 4'b0001 << src;
        d_pop[src*40 +: 40] = data;
        pndng = m;
        step();
        chk({tag, "_pop"},  64'(pop),  64'(m));
        chk({tag, "_busy"}, 64'(busy), 64'h1);
        step();
        pndng = '0;
        chk({tag, "_push"},  64'(push),   64'(exp_push));
        chk({tag, "_drop"},  64'(drop),   64'(exp_drop));
        chk({tag, "_dpush"}, 64'(d_push), 64'(data));
        chk({tag, "_pop0"},  64'(pop),    64'h0);
        step();
        chk({tag, "_idle_push"}, 64'(push),   64'h0);
        chk({tag, "_idle_busy"}, 64'(busy),   64'h0);
        chk({tag, "_hold"},      64'(d_push), 64'(data));
    endtask

    logic [3:0] pops [8];
    int         at   [8];
    int         order [5];
    int         n;

    initial begin
        order = '{0, 1, 2, 3, 0};

        do_reset("rst0");

        do_packet("t1", 0, 40'h02A5A5A5A5, 4'b0100, 1'b0);

        do_reset("rst2");
        for (int i = 0; i < 4; i++) begin
            d_pop[i*40 +: 40] = {8'((i + 1) % 4), 32'hC0DE0000 + 32'(i)};
        end
        pndng = 4'b1111;
        n = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            step();
            if (pop != 4'b0000 && n < 8) begin
                pops[n] = pop;
                at[n]   = cyc;
                n++;
            end
        end
        pndng = '0;
        step();
        step();
        chk("t2_count", 64'(n >= 5), 64'h1);
        chk("t2_first_at", 64'(at[0]), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("t2_order", 64'(pops[k]), 64'(4'b0001 << order[k]));
            if (k > 0) chk("t2_gap", 64'(at[k] - at[k-1]), 64'd3);
        end

        do_packet("t3", 1, 40'hFF11112222, 4'b1101, 1'b0);

        do_packet("t4a", 3, 40'h03DEADBEEF, 4'b0000, 1'b1);
        do_packet("t4b", 3, 40'h09CAFEF00D, 4'b0000, 1'b1);

        do_packet("t5pre", 1, 40'h0012345678, 4'b0001, 1'b0);
        d_pop[2*40 +: 40] = 40'h0133334444;
        d_pop[3*40 +: 40] = 40'h0055556666;
        pndng = 4'b0100;
        step();
        pndng = 4'b0000;
        #1;
        chk("t5_nopop", 64'(pop),  64'h0);
        chk("t5_busy",  64'(busy), 64'h1);
        step();
        chk("t5_nopush", 64'(push), 64'h0);
        chk("t5_nodrop", 64'(drop), 64'h0);
        chk("t5_idle",   64'(busy), 64'h0);
        pndng = 4'b1100;
        step();
        chk("t5_regrant", 64'(pop), 64'b0100);
        step();
        pndng = '0;
        chk("t5_push", 64'(push), 64'b0010);
        step();

        d_pop[0 +: 40] = 40'h02BBBBCCCC;
        pndng = 4'b0001;
        step();
        step();
        pndng = '0;
        chk("t6_route", 64'(push), 64'b0100);
        #2 reset = 1'b1;
        #1;
        chk("t6_push",  64'(push),   64'h0);
        chk("t6_dpush", 64'(d_push), 64'h0);
        chk("t6_busy",  64'(busy),   64'h0);
        chk("t6_drop",  64'(drop),   64'h0);
        @(negedge clk);
        reset = 1'b0;
        d_pop[3*40 +: 40] = 40'h0077778888;
        pndng = 4'b1000;
        step();
        chk("t6_pop", 64'(pop), 64'b1000);
        step();
        pndng = '0;
        chk("t6_push3", 64'(push), 64'b0001);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
